// File: rtl/turn_controller_if.sv
// Handshake/bus bundle between the input decode, the turn controller and
// the display/score logic.
interface turn_controller_if;
    logic       start;
    logic [7:0] start_val;
    logic       move_valid;
    logic [3:0] move_root;
    logic       move_ready;
    logic [7:0] game_state;
    logic       player;
    logic [7:0] p1_score;
    logic [7:0] p2_score;
    logic       move_error;
    logic       round_over;
    logic       match_over;

    modport master (
        output start, start_val, move_valid, move_root,
        input  move_ready, game_state, player, p1_score, p2_score,
               move_error, round_over, match_over
    );

    modport slave (
        input  start, start_val, move_valid, move_root,
        output move_ready, game_state, player, p1_score, p2_score,
               move_error, round_over, match_over
    );
endinterface

// File: rtl/turn_controller.sv
// Subtract-a-Square match sequencer: accepts one move per turn, checks it
// against the pile, credits thermometer scores and ends the match.
module turn_controller #(
    parameter int WIN_SCORE = 5
) (
    input  logic              clk,
    input  logic              reset,
    turn_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        SCORE,
        MATCH_OVER
    } state_e;

    // Thermometer pattern with WIN_SCORE ones filled from the MSB.
    localparam logic [7:0] WIN_MASK = ~(8'hFF >> WIN_SCORE);

    state_e     state_q, state_d;
    logic [7:0] game_state_q, game_state_d;
    logic       player_q, player_d;
    logic [7:0] p1_score_q, p1_score_d;
    logic [7:0] p2_score_q, p2_score_d;
    logic [7:0] start_lat_q, start_lat_d;
    logic [3:0] root_q, root_d;
    logic       move_ready_q, move_ready_d;
    logic       move_error_q, move_error_d;
    logic       round_over_q, round_over_d;
    logic       match_over_q, match_over_d;

    logic [7:0] sq;
    logic [7:0] remain;
    logic [7:0] win_new;

    always_comb begin
        state_d      = state_q;
        game_state_d = game_state_q;
        player_d     = player_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        start_lat_d  = start_lat_q;
        root_d       = root_q;
        move_error_d = 1'b0;
        round_over_d = 1'b0;
        sq           = {4'd0, root_q} * {4'd0, root_q};
        remain       = game_state_q - sq;
        win_new      = player_q ? {1'b1, p2_score_q[7:1]} : {1'b1, p1_score_q[7:1]};

        case (state_q)
            IDLE, MATCH_OVER: begin
                if (bus.start && (bus.start_val != 8'd0)) begin
                    start_lat_d  = bus.start_val;
                    game_state_d = bus.start_val;
                    player_d     = 1'b0;
                    p1_score_d   = 8'h00;
                    p2_score_d   = 8'h00;
                    state_d      = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                if (bus.move_valid) begin
                    root_d  = bus.move_root;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((root_q == 4'd0) || (sq > game_state_q)) begin
                    move_error_d = 1'b1;
                    state_d      = WAIT_MOVE;
                end else begin
                    game_state_d = remain;
                    if (remain != 8'd0) begin
                        player_d = ~player_q;
                        state_d  = WAIT_MOVE;
                    end else begin
                        state_d  = SCORE;
                    end
                end
            end
            SCORE: begin
                // The player who emptied the pile is still player_q.
                if (player_q) p2_score_d = win_new;
                else          p1_score_d = win_new;
                round_over_d = 1'b1;
                if (win_new == WIN_MASK) begin
                    state_d = MATCH_OVER;
                end else begin
                    game_state_d = start_lat_q;
                    player_d     = ~player_q;
                    state_d      = WAIT_MOVE;
                end
            end
            default: state_d = IDLE;
        endcase

        move_ready_d = (state_d == WAIT_MOVE);
        match_over_d = (state_d == MATCH_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            game_state_q <= 8'd0;
            player_q     <= 1'b0;
            p1_score_q   <= 8'h00;
            p2_score_q   <= 8'h00;
            start_lat_q  <= 8'd0;
            root_q       <= 4'd0;
            move_ready_q <= 1'b0;
            move_error_q <= 1'b0;
            round_over_q <= 1'b0;
            match_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_state_q <= game_state_d;
            player_q     <= player_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            start_lat_q  <= start_lat_d;
            root_q       <= root_d;
            move_ready_q <= move_ready_d;
            move_error_q <= move_error_d;
            round_over_q <= round_over_d;
            match_over_q <= match_over_d;
        end
    end

    assign bus.move_ready = move_ready_q;
    assign bus.game_state = game_state_q;
    assign bus.player     = player_q;
    assign bus.p1_score   = p1_score_q;
    assign bus.p2_score   = p2_score_q;
    assign bus.move_error = move_error_q;
    assign bus.round_over = round_over_q;
    assign bus.match_over = match_over_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: a turn-level game model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_turn_controller;
    localparam int WIN = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    turn_controller_if bus();

    turn_controller #(.WIN_SCORE(WIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Game model: pile, whose turn, win counts, and the moves still in flight.
    int m_gs, m_player, m_lat, m_root, m_sq;
    int m_wins [2];
    bit m_ready, m_err, m_round, m_over, m_pmove, m_pscore;

    function automatic logic [7:0] thermo(input int n);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < n; i++) t[7-i] = 1'b1;
        return t;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_gs = 0; m_player = 0; m_lat = 0; m_root = 0;
            m_wins[0] = 0; m_wins[1] = 0;
            m_ready = 0; m_err = 0; m_round = 0; m_over = 0;
            m_pmove = 0; m_pscore = 0;
        end else begin
            m_err = 0;
            m_round = 0;
            if (m_pscore) begin
                m_pscore = 0;
                m_wins[m_player] = m_wins[m_player] + 1;
                m_round = 1;
                if (m_wins[m_player] == WIN) begin
                    m_over = 1;
                end else begin
                    m_gs = m_lat;
                    m_player = 1 - m_player;
                    m_ready = 1;
                end
            end else if (m_pmove) begin
                m_pmove = 0;
                m_sq = m_root * m_root;
                m_ready = 1;
                if (m_root == 0 || m_sq > m_gs) begin
                    m_err = 1;
                end else begin
                    m_gs = m_gs - m_sq;
                    if (m_gs == 0) begin
                        m_pscore = 1;
                        m_ready = 0;
                    end else begin
                        m_player = 1 - m_player;
                    end
                end
            end else if (m_ready) begin
                if (bus.move_valid) begin
                    m_pmove = 1;
                    m_root = int'(bus.move_root);
                    m_ready = 0;
                end
            end else if (bus.start && bus.start_val != 8'd0) begin
                m_gs = int'(bus.start_val);
                m_lat = m_gs;
                m_player = 0;
                m_wins[0] = 0; m_wins[1] = 0;
                m_over = 0;
                m_ready = 1;
            end
        end
    end

    task automatic cmp_cycle();
        logic [7:0] e1, e2;
        if (reset) return;
        e1 = thermo(m_wins[0]);
        e2 = thermo(m_wins[1]);
        n_tests++;
        if (bus.game_state !== 8'(m_gs) || bus.player !== 1'(m_player) ||
            bus.p1_score !== e1 || bus.p2_score !== e2 ||
            bus.move_ready !== m_ready || bus.move_error !== m_err ||
            bus.round_over !== m_round || bus.match_over !== m_over) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t got gs=%0d pl=%0d p1=%h p2=%h rdy=%b err=%b rnd=%b ovr=%b want gs=%0d pl=%0d p1=%h p2=%h rdy=%b err=%b rnd=%b ovr=%b",
                     $time, bus.game_state, bus.player, bus.p1_score, bus.p2_score,
                     bus.move_ready, bus.move_error, bus.round_over, bus.match_over,
                     m_gs, m_player, e1, e2, m_ready, m_err, m_round, m_over);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input int v);
        bus.start = 1'b1;
        bus.start_val = 8'(v);
        tick();
        bus.start = 1'b0;
    endtask

    // Returns at the falling edge right after the handshake edge.
    task automatic do_move(input int r);
        int n;
        n = 0;
        while (!bus.move_ready && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (!bus.move_ready) begin
            n_fail++;
            $display("FAIL ready_timeout got move_ready=0 expected 1 within 20 cycles");
        end
        bus.move_valid = 1'b1;
        bus.move_root = 4'(r);
        tick();
        bus.move_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        bus.start = 1'b0; bus.start_val = 8'd0;
        bus.move_valid = 1'b0; bus.move_root = 4'd0;
        reset = 1'b1;
        tick(); tick();
        chk("rst_gs", int'(bus.game_state), 0);
        chk("rst_ready", int'(bus.move_ready), 0);
        chk("rst_p1", int'(bus.p1_score), 0);
        chk("rst_over", int'(bus.match_over), 0);
        reset = 1'b0;
        tick();

        // Reset while a move sits in CHECK.
        do_start(10);
        do_move(3);
        #2 reset = 1'b1;
        #1;
        chk("midchk_gs", int'(bus.game_state), 0);
        chk("midchk_player", int'(bus.player), 0);
        chk("midchk_ready", int'(bus.move_ready), 0);
        chk("midchk_err", int'(bus.move_error), 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("post_rst_ready", int'(bus.move_ready), 0);
        chk("post_rst_gs", int'(bus.game_state), 0);

        // P2 wins a round from pile 10.
        do_start(10);
        chk("t2_start_gs", int'(bus.game_state), 10);
        chk("t2_start_ready", int'(bus.move_ready), 1);
        do_move(3); tick();
        chk("t2_gs1", int'(bus.game_state), 1);
        chk("t2_pl1", int'(bus.player), 1);
        do_move(1); tick();
        chk("t2_gs0", int'(bus.game_state), 0);
        tick();
        chk("t2_p2", int'(bus.p2_score), 8'h80);
        chk("t2_round", int'(bus.round_over), 1);
        chk("t2_gs_reload", int'(bus.game_state), 10);
        chk("t2_player", int'(bus.player), 0);

        // Illegal moves.
        do_move(4); tick();
        chk("t3_err_big", int'(bus.move_error), 1);
        chk("t3_gs", int'(bus.game_state), 10);
        chk("t3_player", int'(bus.player), 0);
        tick();
        chk("t3_err_pulse", int'(bus.move_error), 0);
        do_move(0); tick();
        chk("t3_err_zero", int'(bus.move_error), 1);

        // start in WAIT_MOVE must not restart the match.
        bus.start = 1'b1; bus.start_val = 8'd7;
        tick();
        bus.start = 1'b0;
        chk("start_ignored_gs", int'(bus.game_state), 10);
        chk("start_ignored_p2", int'(bus.p2_score), 8'h80);

        // Zero start value ignored, then P1 wins pile 4.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        do_start(0);
        chk("t4_zero_ready", int'(bus.move_ready), 0);
        tick();
        chk("t4_zero_gs", int'(bus.game_state), 0);
        do_start(4);
        do_move(2); tick();
        chk("t4_gs0", int'(bus.game_state), 0);
        tick();
        chk("t4_p1", int'(bus.p1_score), 8'h80);
        chk("t4_player", int'(bus.player), 1);
        chk("t4_gs", int'(bus.game_state), 4);

        // P2 opens each later round on pile 4; four unit moves hand P1 the win.
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int k = 0; k < 4; k++) begin
                do_move(1);
                tick();
            end
        end
        tick();
        chk("t5_p1", int'(bus.p1_score), 8'hF8);
        chk("t5_p2", int'(bus.p2_score), 0);
        chk("t5_over", int'(bus.match_over), 1);
        chk("t5_ready", int'(bus.move_ready), 0);
        chk("t5_gs", int'(bus.game_state), 0);
        chk("t5_player", int'(bus.player), 0);
        bus.move_valid = 1'b1; bus.move_root = 4'd1;
        tick(); tick(); tick();
        bus.move_valid = 1'b0;
        chk("t5_ignored_err", int'(bus.move_error), 0);
        chk("t5_ignored_p1", int'(bus.p1_score), 8'hF8);
        do_start(0);
        chk("t5_zero_restart", int'(bus.match_over), 1);
        do_start(200);
        chk("t5_restart_over", int'(bus.match_over), 0);
        chk("t5_restart_p1", int'(bus.p1_score), 0);
        chk("t5_restart_gs", int'(bus.game_state), 200);

        // move_valid held high: one acceptance every two cycles.
        bus.move_root = 4'd1;
        bus.move_valid = 1'b1;
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.move_ready) hs++;
            tick();
        end
        bus.move_valid = 1'b0;
        tick(); tick();
        chk("t6_handshakes", hs, 5);
        chk("t6_gs", int'(bus.game_state), 195);
        chk("t6_player", int'(bus.player), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
